series_ctrl: RTL and testbench

Control FSM that sequences the Q8.8 series-evaluation datapath: term register, sum register, 4-bit iteration counter, term-source mux, add/sub unit, `<=` comparator and Q8.8 multiplier. It accepts a start request with an iteration count, and initialises both registers to 1.0. It then runs N multiply/accumulate iterations and reports completion with a one-cycle done pulse. The block sits between the host-side handshake and the datapath instance inside the series top level.

---
 rtl/series_pkg.sv | 16 +
 rtl/series_ctrl_if.sv | 31 +++
 rtl/series_ctrl.sv | 83 ++++++++
 tb/tb_series_ctrl.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/series_pkg.sv
// Shared types and constants for the Q8.8 series-evaluation block.
package series_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_INIT,
    S_CHECK,
    S_MUL,
    S_ACC,
    S_DONE
  } series_state_t;

  localparam logic [15:0] Q88_ONE      = 16'h0100;
  localparam int          SERIES_CNT_W = 4;

endpackage

// File: rtl/series_ctrl_if.sv
// Control-to-datapath/host bundle: request, comparator feedback and Moore strobes.
interface series_ctrl_if #(
  parameter int CNT_W = 4
);
  logic             start;
  logic [CNT_W-1:0] n_terms;
  logic             fin;
  logic [CNT_W-1:0] n_lat;
  logic             term_init;
  logic             sum_init;
  logic             cnt_init;
  logic             term_ld;
  logic             term_sel;
  logic             sum_ld;
  logic             add_mode;
  logic             cnt_en;
  logic             busy;
  logic             done;

  modport master (
    input  start, n_terms, fin,
    output n_lat, term_init, sum_init, cnt_init, term_ld, term_sel,
           sum_ld, add_mode, cnt_en, busy, done
  );

  modport slave (
    output start, n_terms, fin,
    input  n_lat, term_init, sum_init, cnt_init, term_ld, term_sel,
           sum_ld, add_mode, cnt_en, busy, done
  );
endinterface

// File: rtl/series_ctrl.sv
// Sequencer for N multiply/accumulate series iterations; done in cycle 3+3N after accept.
// start ignored unless IDLE; SERIES_ALT_SIGN_EN selects alternating-sign accumulation.
module series_ctrl
  import series_pkg::*;
#(
  parameter int CNT_W = SERIES_CNT_W
) (
  input  logic          clk,
  input  logic          rst,
  series_ctrl_if.master bus
);

  series_state_t    state_q, state_d;
  logic [CNT_W-1:0] n_lat_q, n_lat_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      n_lat_q <= '0;
    end else begin
      state_q <= state_d;
      n_lat_q <= n_lat_d;
    end
  end

  always_comb begin
    state_d = state_q;
    n_lat_d = n_lat_q;
    unique case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          n_lat_d = bus.n_terms;
          state_d = S_INIT;
        end
      end
      S_INIT:  state_d = S_CHECK;
      S_CHECK: state_d = bus.fin ? S_DONE : S_MUL;
      S_MUL:   state_d = S_ACC;
      S_ACC:   state_d = S_CHECK;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Every strobe is decoded from state_q alone so no input reaches an output combinationally.
  assign bus.n_lat     = n_lat_q;
  assign bus.term_init = (state_q == S_INIT);
  assign bus.sum_init  = (state_q == S_INIT);
  assign bus.cnt_init  = (state_q == S_INIT);
  assign bus.term_ld   = (state_q == S_MUL);
  assign bus.term_sel  = (state_q == S_MUL);
  assign bus.sum_ld    = (state_q == S_ACC);
  assign bus.cnt_en    = (state_q == S_ACC);
  assign bus.busy      = (state_q != S_IDLE);
  assign bus.done      = (state_q == S_DONE);

`ifdef SERIES_ALT_SIGN_EN
  logic sign_q, sign_d;

  always_comb begin
    sign_d = sign_q;
    if (state_q == S_INIT) begin
      sign_d = 1'b0;
    end else if (state_q == S_ACC) begin
      sign_d = ~sign_q;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sign_q <= 1'b0;
    end else begin
      sign_q <= sign_d;
    end
  end

  // First iteration subtracts, then alternates.
  assign bus.add_mode = (state_q == S_ACC) ? sign_q : 1'b1;
`else
  assign bus.add_mode = 1'b1;
`endif

endmodule

// File: tb/tb_series_ctrl.sv
// Bench for series_ctrl: behavioural Q8.8 datapath, schedule-based reference, directed runs.
module tb_series_ctrl;
  import series_pkg::*;

`ifdef SERIES_ALT_SIGN_EN
  localparam bit ALT = 1'b1;
`else
  localparam bit ALT = 1'b0;
`endif

  logic clk;
  logic rst_n;
  logic [15:0] dp_x;
  logic [15:0] dp_term, dp_sum;
  logic [3:0]  dp_cnt;
  logic [31:0] prod;

  int n_pass;
  int n_total;

  series_ctrl_if #(.CNT_W(4)) bus ();

  series_ctrl #(.CNT_W(4)) dut (
    .clk (clk),
    .rst (rst_n),
    .bus (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Datapath stand-in driven by the DUT strobes.
  assign prod    = dp_term * dp_x;
  assign bus.fin = ({4'b0, bus.n_lat} <= {4'b0, dp_cnt});

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dp_term <= '0;
      dp_sum  <= '0;
      dp_cnt  <= '0;
    end else begin
      if (bus.term_init)    dp_term <= Q88_ONE;
      else if (bus.term_ld) dp_term <= bus.term_sel ? prod[23:8] : dp_term;
      if (bus.sum_init)     dp_sum  <= Q88_ONE;
      else if (bus.sum_ld)  dp_sum  <= bus.add_mode ? dp_sum + dp_term : dp_sum - dp_term;
      if (bus.cnt_init)     dp_cnt  <= '0;
      else if (bus.cnt_en)  dp_cnt  <= dp_cnt + 4'd1;
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s actual=%0d required=%0d", name, act, exp);
  endtask

  // Reference: cycle index k since acceptance (k=1 is INIT, done at k=3+3N).
  logic       m_act;
  int         m_k;
  int         m_n;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_act <= 1'b0;
      m_k   <= 0;
      m_n   <= 0;
    end else if (m_act) begin
      if (m_k == 3 + 3 * m_n) m_act <= 1'b0;
      else                    m_k   <= m_k + 1;
    end else if (bus.start) begin
      m_act <= 1'b1;
      m_k   <= 1;
      m_n   <= int'(bus.n_terms);
    end
  end

  // Vector order: term_init sum_init cnt_init term_ld term_sel sum_ld add_mode cnt_en busy done
  always @(negedge clk) begin
    logic [9:0] e, a;
    int j;
    e = 10'b0000001000;
    if (m_act) begin
      e[1] = 1'b1;
      if (m_k == 1) begin
        e[9:7] = 3'b111;
      end else if (m_k == 3 + 3 * m_n) begin
        e[0] = 1'b1;
      end else begin
        j = m_k - 2;
        if (j % 3 == 1) begin
          e[6] = 1'b1;
          e[5] = 1'b1;
        end else if (j % 3 == 2) begin
          e[4] = 1'b1;
          e[2] = 1'b1;
          e[3] = ALT ? ((j / 3) % 2 == 1) : 1'b1;
        end
      end
    end
    a = {bus.term_init, bus.sum_init, bus.cnt_init, bus.term_ld, bus.term_sel,
         bus.sum_ld, bus.add_mode, bus.cnt_en, bus.busy, bus.done};
    n_total++;
    if (a == e) n_pass++;
    else $display("FAIL outputs t=%0t k=%0d actual=%b required=%b", $time, m_k, a, e);
    chk("n_lat", int'(bus.n_lat), m_act ? m_n : int'(bus.n_lat) & 0 | m_n);
  end

  function automatic int series_sum(input int n, input int x);
    int t, s;
    t = 256;
    s = 256;
    for (int i = 0; i < n; i++) begin
      t = ((t * x) >> 8) & 16'hFFFF;
      if (ALT && (i % 2 == 0)) s = (s - t) & 16'hFFFF;
      else                     s = (s + t) & 16'hFFFF;
    end
    return s;
  endfunction

  // One request; optional stray start at cycle inj, optional start during DONE.
  task automatic run(input string name, input int n, input logic [15:0] x,
                     input int inj, input bit start_at_done, input int lit_sum);
    int c, n_cnt, n_sum;
    @(negedge clk);
    bus.start   = 1'b1;
    bus.n_terms = 4'(n);
    dp_x        = x;
    @(negedge clk);
    bus.start = 1'b0;
    c     = 1;
    n_cnt = 0;
    n_sum = 0;
    while (!bus.done && c < 100) begin
      if (bus.cnt_en) n_cnt++;
      if (bus.sum_ld) n_sum++;
      if (c == inj) begin
        bus.start   = 1'b1;
        bus.n_terms = 4'd2;
      end else begin
        bus.start = 1'b0;
      end
      @(negedge clk);
      c++;
    end
    chk({name, " done_cycle"}, c, 3 + 3 * n);
    chk({name, " cnt_en_count"}, n_cnt, n);
    chk({name, " sum_ld_count"}, n_sum, n);
    chk({name, " sum_vs_model"}, int'(dp_sum), series_sum(n, int'(x)));
    if (lit_sum >= 0) chk({name, " sum_literal"}, int'(dp_sum), lit_sum);
    chk({name, " final_cnt"}, int'(dp_cnt), n);
    if (start_at_done) begin
      bus.start   = 1'b1;
      bus.n_terms = 4'd7;
      @(negedge clk);
      bus.start = 1'b0;
      chk({name, " idle_after_done"}, int'(bus.busy), 0);
    end else begin
      @(negedge clk);
    end
  endtask

  initial begin
    int c;
    n_pass      = 0;
    n_total     = 0;
    rst_n       = 1'b0;
    bus.start   = 1'b0;
    bus.n_terms = '0;
    dp_x        = 16'h0080;

    @(negedge clk);
    bus.start   = 1'b1;
    bus.n_terms = 4'd9;
    @(negedge clk);
    chk("reset_busy", int'(bus.busy), 0);
    chk("reset_nlat", int'(bus.n_lat), 0);
    bus.start = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("post_reset_busy", int'(bus.busy), 0);

    run("n0", 0, 16'h0080, -1, 1'b1, 16'h0100);
    run("n3", 3, 16'h0080, -1, 1'b0, ALT ? 16'h00A0 : 16'h01E0);
    run("n5_busy_start", 5, 16'h0080, 7, 1'b0, -1);

    // Abort in the first ACC cycle of an N=5 run.
    @(negedge clk);
    bus.start   = 1'b1;
    bus.n_terms = 4'd5;
    @(negedge clk);
    bus.start = 1'b0;
    c = 1;
    while (!bus.sum_ld && c < 20) begin
      @(negedge clk);
      c++;
    end
    chk("abort_in_acc_cycle", c, 4);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_busy", int'(bus.busy), 0);
    chk("abort_strobes", int'({bus.sum_ld, bus.cnt_en, bus.term_ld, bus.done}), 0);
    @(negedge clk);
    rst_n = 1'b1;
    run("n1_after_abort", 1, 16'h0080, -1, 1'b0, ALT ? 16'h0080 : 16'h0180);

    run("n15", 15, 16'h0080, -1, 1'b0, -1);
    run("n4_x1p5", 4, 16'h0180, -1, 1'b0, -1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
